// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: control bundle plus LANES data lanes behind a
// valid/ready handshake, with optional skid entry, flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        stall_cnt
);
    localparam int BUS_W = LANES * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (LANES < 1) begin : g_bad_lanes
        $error("pipe_stage_reg: LANES must be >= 1");
    end
    if (CTRL_W < 1) begin : g_bad_ctrl
        $error("pipe_stage_reg: CTRL_W must be >= 1");
    end
    if (SKID != 0 && SKID != 1) begin : g_bad_skid
        $error("pipe_stage_reg: SKID must be 0 or 1");
    end

    // M drives the outputs; S only ever holds the word that arrived while M was stalled.
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [BUS_W-1:0]  m_data;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [BUS_W-1:0]  s_data;

    logic in_xfer;
    logic out_xfer;

    assign in_ready  = (SKID == 1) ? !s_valid : (!m_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = m_valid && out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset as well so out_data reads 0 after reset.
            m_valid   <= 1'b0;
            m_ctrl    <= '0;
            m_data    <= '0;
            s_valid   <= 1'b0;
            s_ctrl    <= '0;
            s_data    <= '0;
            stall_cnt <= '0;
        end else begin
            // Flush does not touch the counter; only reset clears it.
            if (m_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (SKID == 1) begin
                if (out_xfer || !m_valid) begin
                    if (s_valid) begin
                        // in_ready was low, so no input competes with the skid word.
                        m_valid <= 1'b1;
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                    end else if (in_xfer) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end else if (in_xfer) begin
                    s_valid <= 1'b1;
                    s_ctrl  <= in_ctrl;
                    s_data  <= in_data;
                end
            end else begin
                if (in_xfer) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (out_xfer) begin
                    m_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance share
// stimulus; a FIFO-of-words reference model predicts the selected instance.
module tb_pipe_stage_reg;
    localparam int CTRL_W = 8;
    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int BUS_W  = LANES * DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [BUS_W-1:0]  data;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, in_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [BUS_W-1:0]  in_data;

    logic              k_in_ready, k_out_valid;
    logic [CTRL_W-1:0] k_out_ctrl;
    logic [BUS_W-1:0]  k_out_data;
    logic [3:0]        k_stall_cnt;
    logic              n_in_ready, n_out_valid;
    logic [CTRL_W-1:0] n_out_ctrl;
    logic [BUS_W-1:0]  n_out_data;
    logic [15:0]       n_stall_cnt;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(k_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(k_out_valid), .out_ready(out_ready),
        .out_ctrl(k_out_ctrl), .out_data(k_out_data), .stall_cnt(k_stall_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_ctrl(n_out_ctrl), .out_data(n_out_data), .stall_cnt(n_stall_cnt)
    );

    // cur selects the instance under test: 0 = skid (capacity 2), 1 = no-skid (capacity 1).
    int                cur = 0;
    logic              obs_in_ready, obs_out_valid;
    logic [CTRL_W-1:0] obs_out_ctrl;
    logic [BUS_W-1:0]  obs_out_data;
    logic [15:0]       obs_stall;

    always_comb begin
        if (cur == 0) begin
            obs_in_ready  = k_in_ready;
            obs_out_valid = k_out_valid;
            obs_out_ctrl  = k_out_ctrl;
            obs_out_data  = k_out_data;
            obs_stall     = {12'd0, k_stall_cnt};
        end else begin
            obs_in_ready  = n_in_ready;
            obs_out_valid = n_out_valid;
            obs_out_ctrl  = n_out_ctrl;
            obs_out_data  = n_out_data;
            obs_stall     = n_stall_cnt;
        end
    end

    word_t       mq[$];
    logic [63:0] m_held;
    int unsigned m_cnt;
    int          checks = 0;
    int          errors = 0;

    function automatic bit model_rdy();
        if (cur == 0) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    // Advance one clock edge and update the FIFO model from the pre-edge inputs.
    task automatic tick();
        bit          rdy, ov;
        int unsigned cmax;
        word_t       w;
        rdy  = model_rdy();
        ov   = mq.size() > 0;
        cmax = (cur == 0) ? 15 : 65535;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_held = '0;
        end else begin
            if (ov && !out_ready && m_cnt != cmax) m_cnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (ov && out_ready) w = mq.pop_front();
                if (in_valid && rdy) mq.push_back({in_ctrl, in_data});
            end
            if (mq.size() > 0) m_held = mq[0].data;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cur = 0;
        do_reset();
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", obs_out_valid); end
        checks++; if (obs_out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl got %h want 00", obs_out_ctrl); end
        checks++; if (obs_out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", obs_out_data); end
        checks++; if (obs_stall !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", obs_stall); end
        checks++; if (k_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_skid got %0b want 1", k_in_ready); end
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_noskid got %0b want 1", n_in_ready); end
    endtask

    task automatic test_single();
        cur = 0;
        in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 64'h11111111_22222222; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (obs_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", obs_out_valid); end
        checks++; if (obs_out_ctrl !== 8'hA5) begin errors++; $display("FAIL single_ctrl got %h want a5", obs_out_ctrl); end
        checks++; if (obs_out_data !== 64'h11111111_22222222) begin errors++; $display("FAIL single_data got %h want 1111111122222222", obs_out_data); end
        checks++; if (obs_stall !== 16'd0) begin errors++; $display("FAIL single_stall got %0d want 0", obs_stall); end
        tick();
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %0b want 0", obs_out_valid); end
        checks++; if (obs_out_ctrl !== 8'h00) begin errors++; $display("FAIL single_bubble_ctrl got %h want 00", obs_out_ctrl); end
        checks++; if (obs_out_data !== 64'h11111111_22222222) begin errors++; $display("FAIL single_held_data got %h want 1111111122222222", obs_out_data); end
    endtask

    task automatic test_stream();
        logic [63:0] d;
        cur = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            d = {$urandom, $urandom};
            in_valid = 1'b1; in_ctrl = 8'(i); in_data = d;
            checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, obs_in_ready); end
            tick();
            checks++; if (obs_out_valid !== 1'b1 || obs_out_ctrl !== 8'(i)) begin
                errors++; $display("FAIL stream_word[%0d] got valid=%0b ctrl=%h want valid=1 ctrl=%h", i, obs_out_valid, obs_out_ctrl, 8'(i)); end
            checks++; if (obs_out_data !== d) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, obs_out_data, d); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %0b want 0", obs_out_valid); end
    endtask

    task automatic test_skid_fill();
        cur = 0;
        do_reset();
        in_valid = 1'b1; in_ctrl = 8'd1; in_data = 64'd101; out_ready = 1'b1;
        tick();
        in_ctrl = 8'd2; in_data = 64'd102; out_ready = 1'b0;
        tick();
        in_ctrl = 8'd3; in_data = 64'd103;
        tick();
        tick();
        checks++; if (obs_out_ctrl !== 8'd1 || obs_out_valid !== 1'b1) begin
            errors++; $display("FAIL skid_head got valid=%0b ctrl=%h want valid=1 ctrl=01", obs_out_valid, obs_out_ctrl); end
        checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_in_ready got %0b want 0", obs_in_ready); end
        checks++; if (obs_stall !== 16'd3) begin errors++; $display("FAIL skid_stall got %0d want 3", obs_stall); end
        out_ready = 1'b1;
        tick();
        checks++; if (obs_out_ctrl !== 8'd2 || obs_out_data !== 64'd102) begin
            errors++; $display("FAIL skid_second got ctrl=%h data=%0d want ctrl=02 data=102", obs_out_ctrl, obs_out_data); end
        checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL skid_reopen_in_ready got %0b want 1", obs_in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (obs_out_ctrl !== 8'd3 || obs_out_data !== 64'd103) begin
            errors++; $display("FAIL skid_third got ctrl=%h data=%0d want ctrl=03 data=103", obs_out_ctrl, obs_out_data); end
        tick();
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL skid_drained got %0b want 0", obs_out_valid); end
    endtask

    task automatic test_flush();
        cur = 0;
        do_reset();
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = 64'h11; out_ready = 1'b1;
        tick();
        in_ctrl = 8'h12; in_data = 64'h12; out_ready = 1'b0;
        tick();
        flush = 1'b1; in_ctrl = 8'h13; in_data = 64'h13;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", obs_out_valid); end
        checks++; if (obs_out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got %h want 00", obs_out_ctrl); end
        checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", obs_in_ready); end
        checks++; if (obs_stall !== 16'd2) begin errors++; $display("FAIL flush_keeps_stall got %0d want 2", obs_stall); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got valid=%0b ctrl=%h want valid=0", i, obs_out_valid, obs_out_ctrl); end
        end
        // Flush with room in the stage: the offered word must still be dropped.
        in_valid = 1'b1; in_ctrl = 8'h21; in_data = 64'h21; out_ready = 1'b1;
        tick();
        flush = 1'b1; in_ctrl = 8'h22; in_data = 64'h22; out_ready = 1'b0;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d] got valid=%0b ctrl=%h want valid=0", i, obs_out_valid, obs_out_ctrl); end
            tick();
        end
    endtask

    task automatic test_saturate();
        int unsigned want;
        cur = 0;
        do_reset();
        in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 64'hDEAD_BEEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            want = (k < 15) ? k : 15;
            checks++; if (obs_stall !== 16'(want)) begin errors++; $display("FAIL sat_stall[%0d] got %0d want %0d", k, obs_stall, want); end
        end
        checks++; if (obs_out_valid !== 1'b1 || obs_out_ctrl !== 8'h5A) begin
            errors++; $display("FAIL sat_hold got valid=%0b ctrl=%h want valid=1 ctrl=5a", obs_out_valid, obs_out_ctrl); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (obs_stall !== 16'd0) begin errors++; $display("FAIL sat_rst_stall got %0d want 0", obs_stall); end
        checks++; if (obs_out_valid !== 1'b0 || obs_out_ctrl !== 8'h00 || obs_out_data !== 64'd0) begin
            errors++; $display("FAIL sat_rst_outputs got valid=%0b ctrl=%h data=%h want all 0", obs_out_valid, obs_out_ctrl, obs_out_data); end
        checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL sat_rst_in_ready got %0b want 1", obs_in_ready); end
    endtask

    task automatic test_noskid_toggle();
        int    n_in, n_out;
        word_t sent[$];
        word_t w;
        cur = 1;
        do_reset();
        n_in = 0; n_out = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                in_valid = 1'b1; in_ctrl = 8'(i + 1); in_data = {$urandom, $urandom}; out_ready = (i % 2 == 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            if (obs_out_valid) begin
                checks++; if (obs_in_ready !== out_ready) begin errors++; $display("FAIL toggle_in_ready[%0d] got %0b want %0b", i, obs_in_ready, out_ready); end
            end
            if (obs_out_valid && out_ready) begin
                checks++;
                if (sent.size() == 0) begin
                    errors++; $display("FAIL toggle_extra_word[%0d] got ctrl=%h want none", i, obs_out_ctrl);
                end else begin
                    w = sent.pop_front();
                    if (obs_out_ctrl !== w.ctrl || obs_out_data !== w.data) begin
                        errors++; $display("FAIL toggle_order[%0d] got ctrl=%h want ctrl=%h", i, obs_out_ctrl, w.ctrl); end
                end
                n_out++;
            end
            if (in_valid && obs_in_ready) begin
                sent.push_back({in_ctrl, in_data});
                n_in++;
            end
            tick();
        end
        checks++; if (n_in !== 8) begin errors++; $display("FAIL toggle_accepted got %0d want 8", n_in); end
        checks++; if (n_out !== n_in) begin errors++; $display("FAIL toggle_conservation got out=%0d want %0d", n_out, n_in); end
    endtask

    task automatic test_random(input int inst);
        bit want_v;
        logic [CTRL_W-1:0] want_c;
        cur = inst;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            tick();
            want_v = mq.size() > 0;
            want_c = want_v ? mq[0].ctrl : '0;
            checks++; if (obs_out_valid !== want_v) begin errors++; $display("FAIL rand%0d_valid[%0d] got %0b want %0b", inst, i, obs_out_valid, want_v); end
            checks++; if (obs_out_ctrl !== want_c) begin errors++; $display("FAIL rand%0d_ctrl[%0d] got %h want %h", inst, i, obs_out_ctrl, want_c); end
            checks++; if (obs_out_data !== m_held) begin errors++; $display("FAIL rand%0d_data[%0d] got %h want %h", inst, i, obs_out_data, m_held); end
            checks++; if (obs_stall !== 16'(m_cnt)) begin errors++; $display("FAIL rand%0d_stall[%0d] got %0d want %0d", inst, i, obs_stall, m_cnt); end
            checks++; if (obs_in_ready !== model_rdy()) begin errors++; $display("FAIL rand%0d_in_ready[%0d] got %0b want %0b", inst, i, obs_in_ready, model_rdy()); end
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0; m_held = '0; m_cnt = 0;
        test_reset();
        test_single();
        test_stream();
        test_skid_fill();
        test_flush();
        test_saturate();
        test_noskid_toggle();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
